// File: rtl/pix_pkg.sv
// pix_pkg: shared defaults, address-width helper and FSM state type for the pixel frame writer.
package pix_pkg;
    localparam int PIX_DATA_W = 8;
    localparam int PIX_FRAME_PIXELS = 70176;
    // pix_count must be able to hold FRAME_PIXELS itself, hence the +1
    function automatic int addr_w(input int pixels);
        return $clog2(pixels + 1);
    endfunction
    localparam int PIX_ADDR_W = addr_w(PIX_FRAME_PIXELS);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/pixel_frame_writer_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers; storage is reset so the head reads 0 after rst.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    logic [PW:0] wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    assign empty = wr_ptr == rd_ptr;
    assign full = wr_ptr[PW] != rd_ptr[PW] && wr_ptr[PW-1:0] == rd_ptr[PW-1:0];
    assign dout = mem[rd_ptr[PW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[PW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/pixel_frame_writer.sv
// pixel_frame_writer: buffers the filtered pixel stream and writes one frame sequentially
// into the output RAM through a request/grant port; flags frame end and dropped pixels.
module pixel_frame_writer
    import pix_pkg::*;
#(
    parameter int DATA_W = PIX_DATA_W,
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_PIXELS = PIX_FRAME_PIXELS,
    parameter int ADDR_W = addr_w(FRAME_PIXELS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              wr_req,
    input  logic              wr_gnt,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_done,
    output logic              overflow,
    output logic [ADDR_W-1:0] pix_count
);
    state_t state, state_next;
    logic full, empty, push, pop, active, abort, leave, last;
    assign active = state == RUN || state == DRAIN;
    assign abort = active && !en;
    assign leave = abort || (state == DONE && !en);
    assign wr_req = active && !empty;
    assign pop = wr_req && wr_gnt;
    // a full FIFO still takes the pixel when its head leaves in the same cycle
    assign push = state == RUN && en && pix_valid && (!full || pop);
    assign last = pix_count == ADDR_W'(FRAME_PIXELS - 1);
    assign frame_done = state == DONE;
    always_comb begin
        state_next = leave ? IDLE :
                     state == IDLE && en ? RUN :
                     state == RUN && push && last ? DRAIN :
                     state == DRAIN && empty ? DONE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pix_count <= '0;
            wr_addr <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (leave) begin
                pix_count <= '0;
                wr_addr <= '0;
            end else begin
                if (push) pix_count <= pix_count + 1'b1;
                if (pop) wr_addr <= wr_addr + 1'b1;
            end
            if (state == RUN && en && pix_valid && full && !pop) overflow <= 1'b1;
        end
    end
    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .flush(abort),
        .din(pix_data),
        .dout(wr_data),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_pixel_frame_writer.sv
// tb_pixel_frame_writer: randomized frames checked cycle by cycle against a queue-based model,
// plus a per-frame write scoreboard.
module tb_pixel_frame_writer;
    localparam int FP = 24;
    localparam int DEPTH = 16;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
    logic clk = 0, rst = 1, en = 0, pix_valid = 0, wr_gnt = 0;
    logic [DW-1:0] pix_data = '0;
    logic wr_req, frame_done, overflow;
    logic [AW-1:0] wr_addr, pix_count;
    logic [DW-1:0] wr_data;
    int checks = 0, errors = 0;
    int m_st, m_cnt, m_addr;
    bit m_ovf;
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_pix[$];
    int obs_cnt[FP];
    logic [DW-1:0] obs_mem[FP];
    bit bad_addr;
    pixel_frame_writer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .FRAME_PIXELS(FP), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .pix_valid(pix_valid), .pix_data(pix_data),
        .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .overflow(overflow), .pix_count(pix_count)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (!rst && wr_req && wr_gnt) begin
            if (wr_addr < AW'(FP)) begin
                obs_cnt[wr_addr]++;
                obs_mem[wr_addr] = wr_data;
            end else bad_addr = 1;
        end
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask
    task automatic model_step();
        bit req, pop, was_empty;
        req = (m_st == M_RUN || m_st == M_DRAIN) && mq.size() > 0;
        pop = req && wr_gnt;
        was_empty = mq.size() == 0;
        if (m_st == M_IDLE) begin
            if (en) m_st = M_RUN;
        end else if (m_st == M_DONE) begin
            if (!en) begin m_st = M_IDLE; m_cnt = 0; m_addr = 0; end
        end else if (!en) begin
            m_st = M_IDLE; mq.delete(); m_cnt = 0; m_addr = 0;
        end else begin
            if (pop) begin void'(mq.pop_front()); m_addr++; end
            if (m_st == M_RUN) begin
                if (pix_valid) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back(pix_data);
                        exp_pix.push_back(pix_data);
                        m_cnt++;
                        if (m_cnt == FP) m_st = M_DRAIN;
                    end else m_ovf = 1;
                end
            end else if (was_empty) m_st = M_DONE;
        end
    endtask
    task automatic compare_outputs();
        bit req;
        req = (m_st == M_RUN || m_st == M_DRAIN) && mq.size() > 0;
        check("wr_req", wr_req, req);
        check("frame_done", frame_done, m_st == M_DONE);
        check("overflow", overflow, m_ovf);
        check("pix_count", pix_count, m_cnt);
        check("wr_addr", wr_addr, m_addr);
        if (req) check("wr_data", wr_data, mq[0]);
    endtask
    task automatic cycle(input bit e, input bit v, input bit g);
        en = e;
        pix_valid = v;
        pix_data = DW'($urandom);
        wr_gnt = g;
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask
    task automatic frame_clear();
        exp_pix.delete();
        for (int i = 0; i < FP; i++) begin obs_cnt[i] = 0; obs_mem[i] = '0; end
        bad_addr = 0;
    endtask
    task automatic check_mem();
        for (int i = 0; i < FP; i++) begin
            check("mem_cnt", obs_cnt[i], 1);
            check("mem_data", obs_mem[i], i < exp_pix.size() ? exp_pix[i] : 'x);
        end
        check("bad_addr", bad_addr, 0);
    endtask
    task automatic do_reset();
        rst = 1; en = 0; pix_valid = 0; wr_gnt = 0;
        #1;
        m_st = M_IDLE; mq.delete(); m_cnt = 0; m_addr = 0; m_ovf = 0;
        compare_outputs();
        check("rst_wr_data", wr_data, 0);
        @(negedge clk);
        rst = 0;
    endtask
    task automatic run_frame(input int vpct, input int gpct, input bit allow_abort, input bit clear);
        bit aborted, e;
        aborted = 0;
        if (clear) frame_clear();
        for (int c = 0; c < 600 && m_st != M_DONE && !aborted; c++) begin
            e = !(allow_abort && m_st != M_IDLE && $urandom_range(99) < 2);
            cycle(e, $urandom_range(99) < vpct, $urandom_range(99) < gpct);
            aborted = !e;
        end
        if (!aborted) begin
            check("frame_end", frame_done, 1);
            check_mem();
            cycle(1, 1, 1);
            cycle(0, 0, 0);
        end
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        @(negedge clk);
        do_reset();
        // full-rate stream: done two cycles after the last strobe
        frame_clear();
        cycle(1, 0, 1);
        repeat (FP) cycle(1, 1, 1);
        cycle(1, 0, 1);
        check("done_early", frame_done, 0);
        cycle(1, 0, 1);
        check("done_latency", frame_done, 1);
        check("stream_count", pix_count, FP);
        check_mem();
        cycle(0, 0, 0);
        // abort after 3 pixels, then restart from address 0
        frame_clear();
        cycle(1, 0, 0);
        repeat (3) cycle(1, 1, 0);
        cycle(0, 1, 0);
        check("abort_req", wr_req, 0);
        check("abort_cnt", pix_count, 0);
        check("abort_addr", wr_addr, 0);
        run_frame(80, 70, 0, 1);
        // stall: 20 strobes with no grant overflow the FIFO
        frame_clear();
        cycle(1, 0, 0);
        repeat (20) cycle(1, 1, 0);
        check("stall_cnt", pix_count, DEPTH);
        check("stall_ovf", overflow, 1);
        check("stall_addr", wr_addr, 0);
        check("stall_data", wr_data, exp_pix[0]);
        cycle(1, 1, 1);
        check("full_pop_cnt", pix_count, DEPTH + 1);
        check("full_pop_req", wr_req, 1);
        run_frame(90, 100, 0, 0);
        // overflow survives abort and later frames
        for (int f = 0; f < 12; f++) run_frame($urandom_range(100, 40), $urandom_range(100, 30), 1, 1);
        check("ovf_sticky", overflow, 1);
        // async reset mid-RUN with 5 queued entries
        frame_clear();
        cycle(1, 0, 0);
        repeat (5) cycle(1, 1, 0);
        check("pre_rst_cnt", pix_count, 5);
        #2;
        do_reset();
        run_frame(70, 60, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
